tag_cmp: RTL and testbench



---
 rtl/tag_cmp.sv | 120 ++++++++++++
 tb/tb_tag_cmp.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tag_cmp.sv
// Cache-line types shared by the data-cache SRAM path, followed by tag_cmp:
// a fixed-priority SRAM port arbiter with a one-cycle-delayed tag compare.
package std_cache_pkg;
  localparam int DCACHE_INDEX_WIDTH = 12;
  localparam int DCACHE_TAG_WIDTH   = 44;
  localparam int DCACHE_LINE_WIDTH  = 128;
  localparam int DCACHE_SET_ASSOC   = 8;

  typedef struct packed {
    logic [DCACHE_TAG_WIDTH-1:0]  tag;
    logic [DCACHE_LINE_WIDTH-1:0] data;
    logic                         valid;
    logic                         dirty;
  } cache_line_t;

  typedef struct packed {
    logic [(DCACHE_TAG_WIDTH+7)/8-1:0] tag;
    logic [DCACHE_LINE_WIDTH/8-1:0]    data;
    logic [DCACHE_SET_ASSOC-1:0]       vldrty;
  } cl_be_t;
endpackage

// Purpose: fixed-priority arbitration of NR_PORTS onto one SRAM; per-way tag hit for the previous winner.
// Latency: grant and SRAM request are combinational; hit_way_o is valid the cycle after the grant.
// Backpressure: losers see gnt_o low and must hold their request; nothing is buffered here.
// Ports:
//   clk_i/rst_ni              clock, asynchronous active-low reset
//   req_i/addr_i/wdata_i/we_i/be_i  per-port SRAM request; gnt_o one-hot grant to the winner
//   tag_i                     per-port compare tag, presented the cycle after that port's grant
//   req_o/addr_o/wdata_o/we_o/be_o  winner's request towards the SRAM (all zero when idle)
//   rdata_i/rdata_o           SRAM read data (one-cycle latency), forwarded unmodified to all ports
//   hit_way_o                 per-way hit for the port granted in the previous cycle
module tag_cmp #(
  parameter int NR_PORTS         = 4,
  parameter int ADDR_WIDTH       = std_cache_pkg::DCACHE_INDEX_WIDTH,
  parameter int DCACHE_SET_ASSOC = 8
) (
  input  logic                                                  clk_i,
  input  logic                                                  rst_ni,
  input  logic [NR_PORTS-1:0][DCACHE_SET_ASSOC-1:0]             req_i,
  output logic [NR_PORTS-1:0]                                   gnt_o,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]                   addr_i,
  input  std_cache_pkg::cache_line_t [NR_PORTS-1:0]             wdata_i,
  input  logic [NR_PORTS-1:0]                                   we_i,
  input  std_cache_pkg::cl_be_t [NR_PORTS-1:0]                  be_i,
  input  logic [NR_PORTS-1:0][std_cache_pkg::DCACHE_TAG_WIDTH-1:0] tag_i,
  output std_cache_pkg::cache_line_t [DCACHE_SET_ASSOC-1:0]     rdata_o,
  output logic [DCACHE_SET_ASSOC-1:0]                           hit_way_o,
  output logic [DCACHE_SET_ASSOC-1:0]                           req_o,
  output logic [ADDR_WIDTH-1:0]                                 addr_o,
  output std_cache_pkg::cache_line_t                            wdata_o,
  output logic                                                  we_o,
  output std_cache_pkg::cl_be_t                                 be_o,
  input  std_cache_pkg::cache_line_t [DCACHE_SET_ASSOC-1:0]     rdata_i
);

  logic [NR_PORTS-1:0]                         w_gnt;
  logic                                        w_found;
  logic [NR_PORTS-1:0]                         id_q;
  logic [std_cache_pkg::DCACHE_TAG_WIDTH-1:0]  w_sel_tag;
  logic                                        w_id_any;

  // Lowest-index requesting port wins; its request is steered to the SRAM.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    req_o   = '0;
    addr_o  = '0;
    wdata_o = '0;
    we_o    = 1'b0;
    be_o    = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      if (!w_found && (|req_i[i])) begin
        w_found  = 1'b1;
        w_gnt[i] = 1'b1;
        req_o    = req_i[i];
        addr_o   = addr_i[i];
        wdata_o  = wdata_i[i];
        we_o     = we_i[i];
        be_o     = be_i[i];
      end
    end
  end

  assign gnt_o = w_gnt;

  // Remembers which port owns the read data arriving next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q <= '0;
    end else begin
      id_q <= w_gnt;
    end
  end

  // AND-OR select keeps the tag at zero when nobody was granted.
  always_comb begin
    w_sel_tag = '0;
    for (int i = 0; i < NR_PORTS; i++) begin
      w_sel_tag = w_sel_tag | (tag_i[i] & {std_cache_pkg::DCACHE_TAG_WIDTH{id_q[i]}});
    end
  end

  // Gate with id_q so a valid line with tag zero cannot hit after an idle cycle.
  assign w_id_any = |id_q;

  always_comb begin
    hit_way_o = '0;
    for (int j = 0; j < DCACHE_SET_ASSOC; j++) begin
      hit_way_o[j] = w_id_any & rdata_i[j].valid & (rdata_i[j].tag == w_sel_tag);
    end
  end

  assign rdata_o = rdata_i;

  // A line may live in at most one way; more than one hit means corrupted tags.
  a_hit_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(hit_way_o))
    else $error("tag_cmp: more than one way hit, hit_way_o=%b", hit_way_o);

endmodule

// File: tb/tb_tag_cmp.sv
module tb_tag_cmp;
  import std_cache_pkg::*;

  localparam int NP = 4;
  localparam int NW = 8;
  localparam int AW = DCACHE_INDEX_WIDTH;
  localparam int TW = DCACHE_TAG_WIDTH;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [NP-1:0][NW-1:0]     req_i = '0;
  logic [NP-1:0]             gnt_o;
  logic [NP-1:0][AW-1:0]     addr_i = '0;
  cache_line_t [NP-1:0]      wdata_i = '0;
  logic [NP-1:0]             we_i = '0;
  cl_be_t [NP-1:0]           be_i = '0;
  logic [NP-1:0][TW-1:0]     tag_i = '0;
  cache_line_t [NW-1:0]      rdata_o;
  logic [NW-1:0]             hit_way_o;
  logic [NW-1:0]             req_o;
  logic [AW-1:0]             addr_o;
  cache_line_t               wdata_o;
  logic                      we_o;
  cl_be_t                    be_o;
  cache_line_t [NW-1:0]      rdata_i = '0;

  int n_tests = 0;
  int n_fail  = 0;

  tag_cmp #(.NR_PORTS(NP), .ADDR_WIDTH(AW), .DCACHE_SET_ASSOC(NW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .gnt_o(gnt_o), .addr_i(addr_i),
    .wdata_i(wdata_i), .we_i(we_i), .be_i(be_i), .tag_i(tag_i), .rdata_o(rdata_o),
    .hit_way_o(hit_way_o), .req_o(req_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .we_o(we_o), .be_o(be_o), .rdata_i(rdata_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus timing: drive 1 time unit after the rising edge, sample on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_i = '0; addr_i = '0; wdata_i = '0; we_i = '0; be_i = '0; tag_i = '0; rdata_i = '0;
  endtask

  function automatic cache_line_t rand_line();
    logic [191:0] r;
    for (int k = 0; k < 6; k++) r[k*32 +: 32] = $urandom();
    return r[$bits(cache_line_t)-1:0];
  endfunction

  function automatic cl_be_t rand_be();
    logic [31:0] r;
    r = $urandom();
    return r[$bits(cl_be_t)-1:0];
  endfunction

  task automatic test_reset();
    clear_inputs();
    rdata_i[0].valid = 1'b1;
    #3;
    n_tests++; if (hit_way_o !== 8'h00) begin n_fail++; $display("FAIL reset_hit: got %h want 00", hit_way_o); end
    n_tests++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt_o); end
    n_tests++; if (req_o !== 8'h00) begin n_fail++; $display("FAIL reset_req: got %h want 00", req_o); end
    // Combinational path is live while reset is held.
    req_i[1] = 8'h03; addr_i[1] = 12'h3C5;
    #1;
    n_tests++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL reset_comb_gnt: got %b want 0010", gnt_o); end
    n_tests++; if (addr_o !== 12'h3C5) begin n_fail++; $display("FAIL reset_comb_addr: got %h want 3c5", addr_o); end
    @(posedge clk); @(posedge clk);
    #1;
    n_tests++; if (hit_way_o !== 8'h00) begin n_fail++; $display("FAIL reset_hold_hit: got %h want 00", hit_way_o); end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    next_cycle();
    clear_inputs();
    req_i[1] = 8'hFF; addr_i[1] = 12'h010;
    req_i[3] = 8'hFF; addr_i[3] = 12'h020;
    @(negedge clk);
    n_tests++; if (gnt_o !== 4'b0010) begin n_fail++; $display("FAIL prio_gnt: got %b want 0010", gnt_o); end
    n_tests++; if (addr_o !== 12'h010) begin n_fail++; $display("FAIL prio_addr: got %h want 010", addr_o); end
    n_tests++; if (req_o !== 8'hFF) begin n_fail++; $display("FAIL prio_req: got %h want ff", req_o); end
    next_cycle();
    req_i[1] = '0;
    @(negedge clk);
    n_tests++; if (gnt_o !== 4'b1000) begin n_fail++; $display("FAIL prio_next_gnt: got %b want 1000", gnt_o); end
    n_tests++; if (addr_o !== 12'h020) begin n_fail++; $display("FAIL prio_next_addr: got %h want 020", addr_o); end
    next_cycle();
    clear_inputs();
  endtask

  // Port 2 granted, then way 5 carries its tag; valid controls whether it hits.
  task automatic test_hit_way(input logic way5_valid);
    cache_line_t [NW-1:0] lines;
    logic [NW-1:0] exp_hit;
    next_cycle();
    clear_inputs();
    req_i[2] = 8'h01; addr_i[2] = 12'h0AA;
    @(negedge clk);
    n_tests++; if (gnt_o !== 4'b0100) begin n_fail++; $display("FAIL hit_gnt: got %b want 0100", gnt_o); end
    next_cycle();
    req_i = '0;
    tag_i[2] = 44'hABC;
    for (int j = 0; j < NW; j++) begin
      lines[j] = rand_line();
      lines[j].tag = 44'(j + 1);
      lines[j].valid = 1'b1;
    end
    lines[5].tag = 44'hABC;
    lines[5].valid = way5_valid;
    rdata_i = lines;
    exp_hit = way5_valid ? 8'h20 : 8'h00;
    @(negedge clk);
    n_tests++; if (hit_way_o !== exp_hit) begin n_fail++; $display("FAIL hit_way(v=%0b): got %h want %h", way5_valid, hit_way_o, exp_hit); end
    n_tests++; if (rdata_o !== lines) begin n_fail++; $display("FAIL hit_rdata: got %h want %h", rdata_o[5].tag, lines[5].tag); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_idle();
    next_cycle();
    clear_inputs();
    next_cycle();
    rdata_i[0].valid = 1'b1;
    @(negedge clk);
    n_tests++; if (hit_way_o !== 8'h00) begin n_fail++; $display("FAIL idle_hit: got %h want 00", hit_way_o); end
    n_tests++; if (gnt_o !== 4'b0000) begin n_fail++; $display("FAIL idle_gnt: got %b want 0000", gnt_o); end
    n_tests++; if (req_o !== 8'h00) begin n_fail++; $display("FAIL idle_req: got %h want 00", req_o); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_write();
    cache_line_t wl;
    cl_be_t      wb;
    next_cycle();
    clear_inputs();
    wl = rand_line();
    wl.data = {16{8'h5A}};
    wb = rand_be();
    wb.data = '1;
    req_i[0] = 8'h04; we_i[0] = 1'b1; wdata_i[0] = wl; be_i[0] = wb; addr_i[0] = 12'h155;
    req_i[2] = 8'h80; we_i[2] = 1'b0; wdata_i[2] = rand_line(); be_i[2] = rand_be(); addr_i[2] = 12'h2AA;
    @(negedge clk);
    n_tests++; if (we_o !== 1'b1) begin n_fail++; $display("FAIL write_we: got %b want 1", we_o); end
    n_tests++; if (be_o !== wb) begin n_fail++; $display("FAIL write_be: got %h want %h", be_o, wb); end
    n_tests++; if (wdata_o !== wl) begin n_fail++; $display("FAIL write_wdata: got %h want %h", wdata_o.data, wl.data); end
    n_tests++; if (req_o !== 8'h04) begin n_fail++; $display("FAIL write_req: got %h want 04", req_o); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    next_cycle();
    clear_inputs();
    req_i[2] = 8'h10;
    next_cycle();
    req_i = '0;
    tag_i[2] = 44'h123;
    rdata_i[3].tag = 44'h123; rdata_i[3].valid = 1'b1;
    #2;
    n_tests++; if (hit_way_o !== 8'h08) begin n_fail++; $display("FAIL arst_pre_hit: got %h want 08", hit_way_o); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (hit_way_o !== 8'h00) begin n_fail++; $display("FAIL arst_hit: got %h want 00", hit_way_o); end
    // First edge after release must capture the current winner.
    req_i[3] = 8'h01;
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    req_i = '0;
    tag_i[3] = 44'h777;
    rdata_i = '0;
    rdata_i[1].tag = 44'h777; rdata_i[1].valid = 1'b1;
    @(negedge clk);
    n_tests++; if (hit_way_o !== 8'h02) begin n_fail++; $display("FAIL arst_release_hit: got %h want 02", hit_way_o); end
    next_cycle();
    clear_inputs();
  endtask

  // Random traffic against a model: winner = lowest set bit of the requesting-port vector,
  // hits use the tag presented this cycle by last cycle's winner.
  task automatic test_random();
    int prev_win;
    next_cycle();
    clear_inputs();
    prev_win = -1;
    for (int c = 0; c < 400; c++) begin
      logic [NP-1:0] pv, eg;
      logic [NW-1:0] exp_hit;
      int win, hj;
      cache_line_t [NW-1:0] lines;
      next_cycle();
      for (int p = 0; p < NP; p++) begin
        req_i[p]   = ($urandom_range(0, 9) < 4) ? 8'($urandom_range(1, 255)) : 8'h00;
        addr_i[p]  = 12'($urandom());
        wdata_i[p] = rand_line();
        we_i[p]    = 1'($urandom_range(0, 1));
        be_i[p]    = rand_be();
        tag_i[p]   = {12'($urandom()), $urandom()};
      end
      for (int j = 0; j < NW; j++) lines[j] = rand_line();
      exp_hit = '0;
      if (prev_win >= 0) begin
        for (int j = 0; j < NW; j++)
          if (lines[j].tag == tag_i[prev_win]) lines[j].tag[0] = ~lines[j].tag[0];
        if ($urandom_range(0, 2) != 0) begin
          hj = $urandom_range(0, NW - 1);
          lines[hj].tag = tag_i[prev_win];
          if (lines[hj].valid) exp_hit[hj] = 1'b1;
        end
      end
      rdata_i = lines;
      for (int p = 0; p < NP; p++) pv[p] = |req_i[p];
      eg = pv & (~pv + 4'd1);
      win = -1;
      for (int p = 0; p < NP; p++) if (eg[p]) win = p;
      @(negedge clk);
      n_tests++; if (gnt_o !== eg) begin n_fail++; $display("FAIL rnd_gnt[%0d]: got %b want %b", c, gnt_o, eg); end
      n_tests++; if (hit_way_o !== exp_hit) begin n_fail++; $display("FAIL rnd_hit[%0d]: got %h want %h", c, hit_way_o, exp_hit); end
      n_tests++; if (rdata_o !== lines) begin n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", c, rdata_o[0].tag, lines[0].tag); end
      if (win < 0) begin
        n_tests++;
        if (req_o !== '0 || addr_o !== '0 || wdata_o !== '0 || we_o !== 1'b0 || be_o !== '0) begin
          n_fail++; $display("FAIL rnd_idle_out[%0d]: req %h addr %h we %b, want all zero", c, req_o, addr_o, we_o);
        end
      end else begin
        n_tests++; if (req_o !== req_i[win]) begin n_fail++; $display("FAIL rnd_req[%0d]: got %h want %h", c, req_o, req_i[win]); end
        n_tests++; if (addr_o !== addr_i[win]) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h want %h", c, addr_o, addr_i[win]); end
        n_tests++; if (wdata_o !== wdata_i[win]) begin n_fail++; $display("FAIL rnd_wdata[%0d]: got %h want %h", c, wdata_o.tag, wdata_i[win].tag); end
        n_tests++; if (we_o !== we_i[win]) begin n_fail++; $display("FAIL rnd_we[%0d]: got %b want %b", c, we_o, we_i[win]); end
        n_tests++; if (be_o !== be_i[win]) begin n_fail++; $display("FAIL rnd_be[%0d]: got %h want %h", c, be_o, be_i[win]); end
      end
      prev_win = win;
    end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_hit_way(1'b1);
    test_hit_way(1'b0);
    test_idle();
    test_write();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
